if_fetch_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register of the 5-stage RV32I core.
- Owns the PC and issues single-outstanding requests to the instruction memory.
- Buffers one returned word across hazard stalls.
- Drives the IF/ID register consumed by decode and by the hazard detection unit.
- Obeys the stall controls (pc_write, if_id_write) and EX-stage branch/jump redirects.

---
 rtl/rv_pkg.sv | 26 ++
 rtl/if_id_reg.sv | 38 +++
 rtl/if_fetch_stage.sv | 142 ++++++++++++++
 tb/tb_if_fetch_stage.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared definitions for the RV32I core pipeline: datapath width, the
// bubble encoding and the instruction-fetch state machine encoding.
package rv_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0 -- architecturally a no-op, used to fill bubbles.
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [XLEN-1:0] INSTR_BYTES = 32'd4;

    // REQ   : one request outstanding at fetch_pc
    // HOLD  : a returned word is parked in the hold buffer, no request
    // DRAIN : an abandoned request is still in flight; its data is discarded
    typedef enum logic [1:0] {
        REQ   = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    // Sequential PC; plain 32-bit wrap-around (0xFFFF_FFFC -> 0x0).
    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
        return pc + INSTR_BYTES;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Flush (bubble) takes priority over load; with
// neither asserted the register holds. A bubble keeps the last PC and only
// replaces the instruction with the no-op and clears valid.
module if_id_reg
    import rv_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = rv_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        load,
    input  logic [31:0] pc_in,
    input  logic [31:0] instr_in,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid
);

    // Register update: bubble, load a fetched word, or hold.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // the pre-edge values; blocking here would create simulation races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_id_pc    <= '0;
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
        end else if (flush) begin
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
        end else if (load) begin
            if_id_pc    <= pc_in;
            if_id_instr <= instr_in;
            if_id_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage of the 5-stage RV32I core. Owns the PC, keeps a
// single request outstanding to instruction memory, parks one returned word
// across hazard stalls and follows EX-stage redirects, draining any
// abandoned request before fetching at the new target.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = rv_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_write,
    input  logic        if_id_write,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid
);

    import rv_pkg::*;

    fetch_state_e    state;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] pend_pc;
    logic [XLEN-1:0] hold_instr;
    logic            adv;
    logic            id_flush;
    logic            id_load;
    logic [XLEN-1:0] id_instr;
    logic            park_word;

    assign adv       = pc_write & if_id_write;
    // While draining, fetch_pc still holds the abandoned address, so the
    // request address stays stable until its response arrives.
    assign imem_addr = fetch_pc;
    // A response that arrives while the stage is stalled gets parked.
    assign park_word = (state == REQ) && imem_rvalid && !adv && !redirect_valid;

    // IF/ID control: redirect bubbles; otherwise load a fresh or parked word,
    // bubble when nothing arrived, or hold.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        id_flush = 1'b0;
        id_load  = 1'b0;
        id_instr = imem_rdata;
        if (redirect_valid) begin
            id_flush = 1'b1;
        end else begin
            unique case (state)
                REQ: begin
                    if (imem_rvalid) id_load  = adv;
                    else             id_flush = if_id_write;
                end
                HOLD: begin
                    id_load  = adv;
                    id_instr = hold_instr;
                end
                default: ;
            endcase
        end
    end

    // Fetch FSM: PC, pending redirect target and the registered request flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= REQ;
            fetch_pc <= RESET_PC;
            pend_pc  <= RESET_PC;
            imem_req <= 1'b1;
        end else begin
            unique case (state)
                REQ: begin
                    if (redirect_valid) begin
                        if (imem_rvalid) begin
                            fetch_pc <= redirect_pc;
                        end else begin
                            pend_pc <= redirect_pc;
                            state   <= DRAIN;
                        end
                    end else if (imem_rvalid) begin
                        if (adv) begin
                            fetch_pc <= next_pc(fetch_pc);
                        end else begin
                            state    <= HOLD;
                            imem_req <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (redirect_valid) begin
                        fetch_pc <= redirect_pc;
                        state    <= REQ;
                        imem_req <= 1'b1;
                    end else if (adv) begin
                        fetch_pc <= next_pc(fetch_pc);
                        state    <= REQ;
                        imem_req <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (imem_rvalid) begin
                        fetch_pc <= redirect_valid ? redirect_pc : pend_pc;
                        state    <= REQ;
                    end else if (redirect_valid) begin
                        pend_pc <= redirect_pc;
                    end
                end
                default: begin
                    state    <= REQ;
                    imem_req <= 1'b1;
                end
            endcase
        end
    end

    // Hold buffer data: captured when a response meets a stall.
    // NOTE: the data is deliberately not reset; it is only read in HOLD,
    // and reset leaves the FSM in REQ, so the buffer is empty by state.
    always_ff @(posedge clk) begin
        if (park_word) hold_instr <= imem_rdata;
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk         (clk),
        .rst         (rst),
        .flush       (id_flush),
        .load        (id_load),
        .pc_in       (fetch_pc),
        .instr_in    (id_instr),
        .if_id_pc    (if_id_pc),
        .if_id_instr (if_id_instr),
        .if_id_valid (if_id_valid)
    );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: a directed vector table, hand-written redirect,
// wrap and async-reset sequences, then randomized stalls/redirects/latencies
// checked against a scoreboard of the IF/ID contents and program order.
module tb_if_fetch_stage;

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pc_write = 1'b1;
    logic        if_id_write = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;

    always #5 clk = ~clk;

    if_fetch_stage #(
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_write       (pc_write),
        .if_id_write    (if_id_write),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .if_id_pc       (if_id_pc),
        .if_id_instr    (if_id_instr),
        .if_id_valid    (if_id_valid)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Memory model state: one outstanding request, latency lat_min..lat_max.
    bit          m_busy = 1'b0;
    int          m_cnt  = 0;
    logic [31:0] m_addr = '0;
    int          lat_min = 1;
    int          lat_max = 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return {a[31:2] ^ 30'h1555_AAAA, 2'b11};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: sample request before the edge, advance the memory, drive
    // the response #1 after the edge.
    task automatic step();
        logic        req_s;
        logic [31:0] addr_s;
        logic        rv_s;
        req_s  = imem_req;
        addr_s = imem_addr;
        rv_s   = imem_rvalid;
        @(posedge clk);
        #1;
        if (m_busy) begin
            check("mem_req_held", 32'(req_s), 32'd1);
            check("mem_addr_stable", addr_s, m_addr);
            if (rv_s) m_busy = 1'b0;
            else      m_cnt--;
        end else if (req_s) begin
            m_busy = 1'b1;
            m_cnt  = int'($urandom_range(lat_max - 1, lat_min - 1));
            m_addr = addr_s;
        end
        imem_rvalid = m_busy && (m_cnt == 0);
        imem_rdata  = imem_rvalid ? mem_word(m_addr) : 32'hDEAD_BEEF;
    endtask

    task automatic do_reset(input int lmin, input int lmax);
        rst            = 1'b1;
        pc_write       = 1'b1;
        if_id_write    = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        m_busy         = 1'b0;
        m_cnt          = 0;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        lat_min        = lmin;
        lat_max        = lmax;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    // Step until IF/ID holds a real instruction, bounded by budget cycles.
    task automatic wait_valid(input string name, input int budget);
        int k;
        k = 0;
        step();
        while (!if_id_valid && k < budget) begin
            step();
            k++;
        end
        check({name, "_valid"}, 32'(if_id_valid), 32'd1);
    endtask

    typedef struct {
        bit          pw;
        bit          iw;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
    } vec_t;

    vec_t vt[9];

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [31:0] exp_next;
        logic        mv;
        logic [31:0] mpc;
        logic [31:0] minstr;
        int          deliveries;

        // ---------------- directed table: fetch, stall, release ----------
        vt[0] = '{1, 1, 1'b1, 32'h0, 1'b0, 32'h0, NOP};
        vt[1] = '{1, 1, 1'b1, 32'h4, 1'b1, 32'h0, 32'h0050_0093};
        vt[2] = '{1, 1, 1'b1, 32'h4, 1'b0, 32'h0, NOP};
        vt[3] = '{0, 0, 1'b0, 32'h4, 1'b0, 32'h0, NOP};
        vt[4] = '{0, 0, 1'b0, 32'h4, 1'b0, 32'h0, NOP};
        vt[5] = '{0, 0, 1'b0, 32'h4, 1'b0, 32'h0, NOP};
        vt[6] = '{1, 1, 1'b1, 32'h8, 1'b1, 32'h4, mem_word(32'h4)};
        vt[7] = '{1, 1, 1'b1, 32'h8, 1'b0, 32'h4, NOP};
        vt[8] = '{1, 1, 1'b1, 32'hC, 1'b1, 32'h8, mem_word(32'h8)};

        do_reset(1, 1);
        check("reset_req", 32'(imem_req), 32'd1);
        check("reset_addr", imem_addr, RESET_PC);
        check("reset_valid", 32'(if_id_valid), 32'd0);
        check("reset_pc", if_id_pc, 32'h0);
        check("reset_instr", if_id_instr, NOP);

        for (int i = 0; i < 9; i++) begin
            pc_write    = vt[i].pw;
            if_id_write = vt[i].iw;
            step();
            check($sformatf("vec%0d_req", i), 32'(imem_req), 32'(vt[i].exp_req));
            check($sformatf("vec%0d_addr", i), imem_addr, vt[i].exp_addr);
            check($sformatf("vec%0d_valid", i), 32'(if_id_valid), 32'(vt[i].exp_valid));
            check($sformatf("vec%0d_pc", i), if_id_pc, vt[i].exp_pc);
            check($sformatf("vec%0d_instr", i), if_id_instr, vt[i].exp_instr);
        end

        // ---------------- redirect with request outstanding (latency 3) --
        do_reset(3, 3);
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        step();
        check("rdr_bubble_valid", 32'(if_id_valid), 32'd0);
        check("rdr_bubble_instr", if_id_instr, NOP);
        check("rdr_old_addr", imem_addr, 32'h0);
        check("rdr_req", 32'(imem_req), 32'd1);
        redirect_valid = 1'b0;
        step();
        check("rdr_drain_addr", imem_addr, 32'h0);
        step();
        check("rdr_dropped_valid", 32'(if_id_valid), 32'd0);
        check("rdr_new_addr", imem_addr, 32'h100);
        wait_valid("rdr_fetch", 20);
        check("rdr_fetch_pc", if_id_pc, 32'h100);
        check("rdr_fetch_instr", if_id_instr, mem_word(32'h100));

        // ---------------- redirect + rvalid + stall in one cycle ---------
        do_reset(1, 1);
        step();
        pc_write       = 1'b0;
        if_id_write    = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        step();
        check("rrv_valid", 32'(if_id_valid), 32'd0);
        check("rrv_instr", if_id_instr, NOP);
        check("rrv_addr", imem_addr, 32'h100);
        check("rrv_req", 32'(imem_req), 32'd1);
        pc_write       = 1'b1;
        if_id_write    = 1'b1;
        redirect_valid = 1'b0;
        step();
        step();
        check("rrv_fetch_valid", 32'(if_id_valid), 32'd1);
        check("rrv_fetch_pc", if_id_pc, 32'h100);

        // ---------------- two redirects during DRAIN --------------------
        do_reset(3, 3);
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        step();
        check("dr2_addr_a", imem_addr, 32'h0);
        redirect_pc = 32'h300;
        step();
        check("dr2_addr_b", imem_addr, 32'h0);
        redirect_valid = 1'b0;
        step();
        check("dr2_addr_after", imem_addr, 32'h300);
        wait_valid("dr2_fetch", 20);
        check("dr2_fetch_pc", if_id_pc, 32'h300);

        // ---------------- PC wrap-around ---------------------------------
        do_reset(1, 1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        step();
        check("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
        wait_valid("wrap_top", 20);
        check("wrap_top_pc", if_id_pc, 32'hFFFF_FFFC);
        check("wrap_top_instr", if_id_instr, mem_word(32'hFFFF_FFFC));
        check("wrap_next_addr", imem_addr, 32'h0);
        wait_valid("wrap_zero", 20);
        check("wrap_zero_pc", if_id_pc, 32'h0);
        check("wrap_zero_instr", if_id_instr, 32'h0050_0093);

        // ---------------- async reset in the middle of DRAIN -------------
        do_reset(1, 1);
        wait_valid("ar_first", 20);
        wait_valid("ar_second", 20);
        check("ar_pre_pc", if_id_pc, 32'h4);
        lat_min = 3;
        lat_max = 3;
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h400;
        step();
        redirect_valid = 1'b0;
        check("ar_pre_addr", imem_addr, 32'h8);
        #2;
        rst = 1'b1;
        #1;
        check("ar_req", 32'(imem_req), 32'd1);
        check("ar_addr", imem_addr, RESET_PC);
        check("ar_valid", 32'(if_id_valid), 32'd0);
        check("ar_pc", if_id_pc, 32'h0);
        check("ar_instr", if_id_instr, NOP);
        do_reset(1, 1);
        wait_valid("ar_restart", 20);
        check("ar_restart_pc", if_id_pc, RESET_PC);

        // ---------------- randomized run with scoreboard ----------------
        do_reset(1, 4);
        exp_next   = RESET_PC;
        mv         = 1'b0;
        mpc        = 32'h0;
        minstr     = NOP;
        deliveries = 0;
        for (int c = 0; c < 3000; c++) begin
            pc_write       = ($urandom_range(0, 3) != 0);
            if_id_write    = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8
                                                         : ($urandom & 32'hFFFF_FFFC);
            step();
            if (redirect_valid) begin
                // Bubble regardless of stalls; program order restarts.
                check("rnd_rdr_valid", 32'(if_id_valid), 32'd0);
                check("rnd_rdr_instr", if_id_instr, NOP);
                check("rnd_rdr_pc", if_id_pc, mpc);
                mv       = 1'b0;
                minstr   = NOP;
                exp_next = redirect_pc;
            end else if (!if_id_write) begin
                // IF/ID must hold.
                check("rnd_hold_valid", 32'(if_id_valid), 32'(mv));
                check("rnd_hold_pc", if_id_pc, mpc);
                check("rnd_hold_instr", if_id_instr, minstr);
            end else if (!if_id_valid) begin
                // Bubble: no-op, PC kept.
                check("rnd_bub_instr", if_id_instr, NOP);
                check("rnd_bub_pc", if_id_pc, mpc);
                mv     = 1'b0;
                minstr = NOP;
            end else if (pc_write) begin
                // Advancing: must be the next instruction in program order.
                check("rnd_adv_pc", if_id_pc, exp_next);
                check("rnd_adv_instr", if_id_instr, mem_word(exp_next));
                mv       = 1'b1;
                mpc      = exp_next;
                minstr   = mem_word(exp_next);
                exp_next = exp_next + 32'd4;
                deliveries++;
            end else begin
                // PC stalled: only an unchanged real instruction is allowed.
                check("rnd_stall_valid", 32'(mv), 32'd1);
                check("rnd_stall_pc", if_id_pc, mpc);
                check("rnd_stall_instr", if_id_instr, minstr);
            end
        end
        check("rnd_progress", 32'(deliveries > 100), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
